// File: rtl/run_seq_pkg.sv
// run_sequencer shared types
// state encoding and counter width
package run_seq_pkg;

    localparam int CYC_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_RUN,
        S_UNLOAD,
        S_FINISH
    } run_state_t;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// saturating up-counter
// sync clear, enable, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // count up while enabled, hold at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: load image, run core, unload result
// index counter and run FSM live here
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int LOAD_N   = 64,
    parameter int RES_BASE = 64,
    parameter int RES_N    = 8,
    parameter int MAX_CYC  = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    output logic             ld_ready,
    output logic             mem_wr_en,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wr_dat,
    input  logic [7:0]       mem_rd_dat,
    output logic             req,
    input  logic             done,
    output logic             res_valid,
    output logic [7:0]       res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             timeout,
    output logic [CYC_W-1:0] cycles
);

    localparam logic [7:0]       LD_LAST  = 8'(LOAD_N - 1);
    localparam logic [7:0]       RES_LAST = 8'(RES_N - 1);
    localparam logic [7:0]       RES_B8   = 8'(RES_BASE);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYC - 1);

    run_state_t state, state_n;
    logic [7:0] idx;
    logic       ld_fire;
    logic       res_fire;
    logic       run_to;
    logic       go;

    assign go       = (state == S_IDLE) && start;
    assign ld_fire  = (state == S_LOAD) && ld_valid;
    assign res_fire = (state == S_UNLOAD) && res_ready;
    // budget hit on the RUN cycle that brings the count to MAX_CYC
    assign run_to   = (state == S_RUN) && !done
                   && (cycles == CYC_LAST);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (start) state_n = S_LOAD;
            S_LOAD:   if (ld_fire && idx == LD_LAST) state_n = S_REQ;
            S_REQ:    state_n = S_RUN;
            S_RUN:    if (done || run_to) state_n = S_UNLOAD;
            S_UNLOAD: if (res_fire && idx == RES_LAST) state_n = S_FINISH;
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // outputs decoded from state and handshakes
    always_comb begin
        ld_ready   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = 8'h00;
        mem_wr_dat = 8'h00;
        req        = 1'b0;
        res_valid  = 1'b0;
        res_data   = 8'h00;
        busy       = (state != S_IDLE);
        unique case (state)
            S_LOAD: begin
                ld_ready   = 1'b1;
                mem_addr   = idx;
                mem_wr_en  = ld_valid;
                mem_wr_dat = ld_valid ? ld_data : 8'h00;
            end
            S_REQ:    req = 1'b1;
            S_UNLOAD: begin
                mem_addr  = RES_B8 + idx;
                res_valid = 1'b1;
                res_data  = mem_rd_dat;
            end
            default: ;
        endcase
    end

    // shared byte index for load and unload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= 8'h00;
        end else if (state == S_IDLE) begin
            idx <= 8'h00;
        end else if (ld_fire) begin
            idx <= (idx == LD_LAST) ? 8'h00 : idx + 8'h01;
        end else if (res_fire) begin
            idx <= (idx == RES_LAST) ? 8'h00 : idx + 8'h01;
        end
    end

    // sticky timeout, cleared when a new run starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (go) begin
            timeout <= 1'b0;
        end else if (run_to) begin
            timeout <= 1'b1;
        end
    end

    sat_counter #(.W(CYC_W)) u_cyc (
        .clk   (clk),
        .reset (reset),
        .clr   (go),
        .en    (state == S_RUN),
        .q     (cycles)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// directed bench for run_sequencer
// small memory model, core done driven by stimulus
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_dat;
    logic [7:0]  mem_rd_dat;
    logic        req;
    logic        done;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        busy;
    logic        timeout;
    logic [15:0] cycles;

    logic [7:0]  mem [256];
    logic [7:0]  q_addr [$];
    logic [7:0]  q_dat [$];
    int          req_cnt;
    int          n_chk;
    int          n_fail;

    run_sequencer #(
        .LOAD_N(4), .RES_BASE(64), .RES_N(2), .MAX_CYC(20)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat),
        .mem_rd_dat(mem_rd_dat), .req(req), .done(done),
        .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy),
        .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    assign mem_rd_dat = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_dat;
            q_addr.push_back(mem_addr);
            q_dat.push_back(mem_wr_dat);
        end
        if (req) req_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // enter LOAD and write 4 bytes base+step*i
    task automatic do_load(input logic [7:0] base,
                           input logic [7:0] step,
                           input bit toggle);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_ready", 32'(ld_ready), 1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + step * 8'(i);
            #1;
            chk("wr_en", 32'(mem_wr_en), 1);
            chk("wr_addr", 32'(mem_addr), 32'(i));
            tick();
            if (toggle && i < 3) begin
                ld_valid = 1'b0;
                #1;
                chk("wr_gap", 32'(mem_wr_en), 0);
                tick();
            end
        end
        ld_valid = 1'b0;
        chk("req_on", 32'(req), 1);
    endtask

    // check the write log for a 4-byte run
    task automatic chk_log(input int from,
                           input logic [7:0] base,
                           input logic [7:0] step);
        chk("log_len", 32'(q_addr.size() - from), 4);
        for (int i = 0; i < 4; i++) begin
            if (from + i < q_addr.size()) begin
                chk("log_addr", 32'(q_addr[from + i]), 32'(i));
                chk("log_dat", 32'(q_dat[from + i]),
                    32'(base + step * 8'(i)));
            end
        end
    endtask

    // drain two result bytes, optional 5-cycle stall
    task automatic drain(input bit stall);
        if (stall) begin
            res_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                chk("stall_vld", 32'(res_valid), 1);
                chk("stall_dat", 32'(res_data), 32'h A5);
                tick();
            end
        end
        res_ready = 1'b1;
        #1;
        chk("res0_addr", 32'(mem_addr), 64);
        chk("res0_dat", 32'(res_data), 32'h A5);
        tick();
        chk("res1_addr", 32'(mem_addr), 65);
        chk("res1_dat", 32'(res_data), 32'h 5A);
        tick();
        res_ready = 1'b0;
        chk("fin_vld", 32'(res_valid), 0);
        chk("fin_busy", 32'(busy), 1);
        tick();
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ix;
        n_chk = 0; n_fail = 0; req_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[64] = 8'hA5;
        mem[65] = 8'h5A;
        reset = 1'b0; start = 1'b0; ld_valid = 1'b0;
        ld_data = 8'h00; done = 1'b0; res_ready = 1'b0;
        #1;
        chk("rst_ctl", 32'({busy, ld_ready, mem_wr_en, req,
                            res_valid, timeout}), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_cyc", 32'(cycles), 0);
        tick();
        reset = 1'b1;
        tick();

        // ld_valid in IDLE is ignored
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        #1;
        chk("idle_wr", 32'(mem_wr_en), 0);
        chk("idle_rdy", 32'(ld_ready), 0);
        tick();
        chk("idle_stay", 32'(busy), 0);
        ld_valid = 1'b0;

        // nominal run: done on RUN cycle 10
        base_ix = q_addr.size();
        req_cnt = 0;
        do_load(8'h11, 8'h11, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("req_off", 32'(req), 0);
        chk("req_done_ign", 32'(res_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_ign", 32'({busy, res_valid, ld_ready}), 32'b100);
        for (int i = 0; i < 8; i++) tick();
        chk("cyc9", 32'(cycles), 9);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("nom_cyc", 32'(cycles), 10);
        chk("nom_to", 32'(timeout), 0);
        chk("nom_vld", 32'(res_valid), 1);
        drain(1'b1);
        chk("nom_req_cnt", 32'(req_cnt), 1);
        chk_log(base_ix, 8'h11, 8'h11);
        chk("hold_cyc", 32'(cycles), 10);

        // backpressured load, then timeout
        base_ix = q_addr.size();
        do_load(8'hB0, 8'h01, 1'b1);
        tick();
        for (int i = 0; i < 19; i++) tick();
        chk("to_pre_cyc", 32'(cycles), 19);
        chk("to_pre", 32'(timeout), 0);
        chk("to_pre_vld", 32'(res_valid), 0);
        tick();
        chk("to_set", 32'(timeout), 1);
        chk("to_cyc", 32'(cycles), 20);
        chk("to_vld", 32'(res_valid), 1);
        drain(1'b0);
        chk("to_sticky", 32'(timeout), 1);
        chk_log(base_ix, 8'hB0, 8'h01);

        // done on the budget cycle: done wins
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_clr", 32'(timeout), 0);
        chk("cyc_clr", 32'(cycles), 0);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hD0;
            tick();
        end
        ld_valid = 1'b0;
        tick();
        for (int i = 0; i < 19; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("tie_to", 32'(timeout), 0);
        chk("tie_vld", 32'(res_valid), 1);
        chk("tie_cyc", 32'(cycles), 20);
        drain(1'b0);

        // reset after two load writes
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hE0;
            tick();
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({busy, ld_ready, mem_wr_en, req,
                                res_valid}), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        tick();
        reset = 1'b1;
        ld_valid = 1'b0;
        tick();

        // fresh run after reset starts at address 0
        base_ix = q_addr.size();
        do_load(8'hC0, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("post_cyc", 32'(cycles), 3);
        drain(1'b0);
        chk_log(base_ix, 8'hC0, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Host-side run controller sitting directly upstream of the processor core (`top_level`). Each run has three phases. First it streams an input image byte-by-byte into the core's data memory write port. It then pulses the core's `req` and waits for the core's `done`, enforcing a cycle-budget timeout. Finally it streams a result window out of data memory on a ready/valid port and reports the run's cycle count.

## Interface
- `LOAD_N`, 64 — bytes loaded into data memory at addresses 0..LOAD_N-1 (1..256).
- `RES_BASE`, 64 — first data-memory address of the result window.
- `RES_N`, 8 — result bytes unloaded (1..256-RES_BASE).
- `MAX_CYC`, 4096 — run-cycle budget before timeout (2..65535).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  begin a run; sampled only in IDLE.
- `ld_valid`  in  1  input byte valid.
- `ld_data`  in  8  input byte.
- `ld_ready`  out  1  sequencer accepts input byte.
- `mem_wr_en`  out  1  data-memory write enable (muxed ahead of core port by integrator).
- `mem_addr`  out  8  data-memory address.
- `mem_wr_dat`  out  8  data-memory write data.
- `mem_rd_dat`  in  8  data-memory read data, combinational from `mem_addr`.
- `req`  out  1  run request to core.
- `done`  in  1  core completion, level.
- `res_valid`  out  1  result byte valid.
- `res_data`  out  8  result byte.
- `res_ready`  in  1  consumer accepts result byte.
- `busy`  out  1  high in every state except IDLE.
- `timeout`  out  1  last run exceeded MAX_CYC; sticky until next `start`.
- `cycles`  out  16  cycles spent in RUN for last run; saturates at 16'hFFFF.

## Operation
- States: IDLE, LOAD, REQ, RUN, UNLOAD, FINISH.
- IDLE:
  - `start`=1 → LOAD.
  - Clears `timeout`, `cycles`, and the index counter.
- LOAD:
  - `ld_ready`=1.
  - On `ld_valid`&`ld_ready`: `mem_wr_en`=1, `mem_addr`=idx, `mem_wr_dat`=`ld_data`, idx++.
  - The write for idx=LOAD_N-1 → REQ, idx cleared.
- REQ:
  - `req`=1 for exactly one cycle → RUN.
  - `done` is ignored in this cycle.
- RUN:
  - `cycles` increments each cycle (saturating).
  - `done`=1 → UNLOAD.
  - Else, if the RUN cycle count reaches MAX_CYC: `timeout`←1 → UNLOAD.
  - `done` and the timeout in the same cycle: `done` wins, `timeout` stays 0.
- UNLOAD:
  - `mem_addr`=RES_BASE+idx; `res_data`=`mem_rd_dat`; `res_valid`=1.
  - On `res_valid`&`res_ready`: idx++.
  - Handshake on idx=RES_N-1 → FINISH.
- FINISH: one cycle, then → IDLE. `cycles` and `timeout` hold until the next `start`.
- Outside their states, `ld_ready`, `mem_wr_en`, `req` and `res_valid` are 0. `mem_addr` is 0 except in LOAD and UNLOAD.
- `start` while busy is ignored.
- `ld_valid` outside LOAD is ignored, and no byte is consumed.
- Address arithmetic is 8-bit. RES_BASE+idx never wraps, guaranteed by the parameter ranges.

## Timing
- Reset values: state IDLE, idx 0, all outputs 0.
- Reset asserted mid-run:
  - Immediately forces IDLE and drops `req`, `mem_wr_en`, `ld_ready` and `res_valid`.
  - Partial memory contents are left as-is.
- `start` at edge t → LOAD at t+1, so `ld_ready`=1 from cycle t+1.
- With `ld_valid` held high, LOAD takes exactly LOAD_N cycles.
- `req` is high in the single cycle after the last load write.
- `done` is first sampled in the cycle after `req` falls.
- `done` seen at edge t → `res_valid`=1 from t+1.
- `res_valid` stays high and `res_data` stays stable while `res_ready`=0.
- Minimum run latency, `start` to IDLE: LOAD_N + 1 + (RUN cycles) + RES_N + 1 + 1.
- Single-clock design; all state changes on the rising edge of `clk`.

## Structure
- Package `run_seq_pkg`: state enum `run_state_t` (6 states) and localparam `CYC_W`=16.
- One sub-module, `sat_counter #(W)`: synchronous clear, enable, saturate at all-ones. Used for `cycles`.
- The index counter and the FSM stay in `run_sequencer`.

## Test plan
- Nominal run (LOAD_N=4, RES_N=2, RES_BASE=64):
  - Stimulus: load 8'h11,8'h22,8'h33,8'h44; model core asserts `done` 10 cycles after `req`.
  - Required: writes to addresses 0..3 in order; `req` high for 1 cycle; `cycles`=10; `res_data` = mem[64] then mem[65]; return to IDLE.
- Backpressure:
  - Stimulus: toggle `ld_valid` 1/0 every cycle; hold `res_ready`=0 for 5 cycles.
  - Required: no skipped or duplicated writes; `res_data` stable while stalled; one byte per accepted handshake.
- Timeout (MAX_CYC=20):
  - Stimulus: `done` never asserted.
  - Required: `timeout`=1 after exactly 20 RUN cycles; unload still runs; `timeout` clears on next `start`.
- `done` and budget in the same cycle:
  - Stimulus: `done` asserted on RUN cycle 20 with MAX_CYC=20.
  - Required: `timeout`=0, UNLOAD entered.
- Ignored inputs:
  - Stimulus: `start` in RUN; `done` held high in REQ; `ld_valid` in IDLE.
  - Required: no state change, `mem_wr_en`=0.
- Reset mid-LOAD:
  - Stimulus: `reset`=0 after 2 writes, then a fresh `start`.
  - Required: all outputs 0 immediately; next run writes from address 0.
